// File: rtl/sw_coeff_loader_if.sv
// Host word stream into the loader and the coefficient write bus toward the expand stage.
`ifndef OVERALL_BITS
`define OVERALL_BITS 16
`endif

interface sw_coeff_loader_if #(
    parameter int LOGN = 13,
    parameter int W    = `OVERALL_BITS
);
    logic [W-1:0]    s_data;
    logic            s_valid;
    logic            s_ready;
    logic [LOGN-1:0] addr_to_expand;
    logic [2*W-1:0]  data_to_expand;
    logic            wea_to_expand;

    modport master (
        input  s_data, s_valid,
        output s_ready, addr_to_expand, data_to_expand, wea_to_expand
    );

    modport slave (
        output s_data, s_valid,
        input  s_ready, addr_to_expand, data_to_expand, wea_to_expand
    );
endinterface

// File: rtl/sw_coeff_loader.sv
// Pairs host re/im words into coefficients and strobes them out at sequential addresses; 1 cycle from im accept to strobe, 4 cycles min per coefficient.
// Backpressure: s_ready only in the two receive states, so the host holds its word through WRITE/GAP/DONE/IDLE.
`ifndef OVERALL_BITS
`define OVERALL_BITS 16
`endif

module sw_coeff_loader #(
    parameter int LOGN = 13,
    parameter int W    = `OVERALL_BITS
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [1:0]            current_n,
    input  logic                  do_expand,
    output logic                  busy,
    output logic                  done,
    sw_coeff_loader_if.master     bus
);

    typedef enum logic [2:0] {
        IDLE,
        RECV_RE,
        RECV_IM,
        WRITE,
        GAP,
        DONE
    } state_t;

    state_t          state;
    state_t          nxt;
    logic [LOGN-1:0] cnt;
    logic [LOGN-1:0] last_idx;
    logic [LOGN-1:0] last_d;
    logic [W-1:0]    re_reg;
    int              sh;
    logic            ready_d;
    logic            wea_d;
    logic            busy_d;
    logic            done_d;

    // Index of the final coefficient: total-1 is a run of sh ones, which also
    // covers the 2^LOGN case without needing an extra counter bit.
    always_comb begin
        sh     = LOGN - 2 + (current_n[1] ? 2 : int'(current_n[0])) - int'(do_expand);
        last_d = {LOGN{1'b1}} >> (LOGN - sh);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= nxt;
        end
    end

    always_comb begin
        nxt = state;
        unique case (state)
            IDLE:    if (start) nxt = RECV_RE;
            RECV_RE: if (bus.s_valid) nxt = RECV_IM;
            RECV_IM: if (bus.s_valid) nxt = WRITE;
            WRITE:   nxt = GAP;
            GAP:     nxt = (cnt == last_idx) ? DONE : RECV_RE;
            DONE:    nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    always_comb begin
        ready_d = (nxt == RECV_RE) || (nxt == RECV_IM);
        wea_d   = (nxt == WRITE);
        busy_d  = (nxt != IDLE);
        done_d  = (nxt == DONE);
    end

    // The data/address outputs double as the im staging register so they
    // change only on the edge that enters WRITE and hold until the next one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.s_ready        <= 1'b0;
            bus.wea_to_expand  <= 1'b0;
            bus.addr_to_expand <= '0;
            bus.data_to_expand <= '0;
            busy               <= 1'b0;
            done               <= 1'b0;
            cnt                <= '0;
            last_idx           <= '0;
            re_reg             <= '0;
        end else begin
            bus.s_ready       <= ready_d;
            bus.wea_to_expand <= wea_d;
            busy              <= busy_d;
            done              <= done_d;
            if (state == IDLE && start) begin
                cnt                <= '0;
                last_idx           <= last_d;
                bus.addr_to_expand <= '0;
            end
            if (state == RECV_RE && bus.s_valid) begin
                re_reg <= bus.s_data;
            end
            if (state == RECV_IM && bus.s_valid) begin
                bus.data_to_expand <= {re_reg, bus.s_data};
                bus.addr_to_expand <= cnt;
            end
            if (state == GAP && cnt != last_idx) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sw_coeff_loader.sv
// Directed bench for sw_coeff_loader: the driver streams known word pairs, a scoreboard of expected coefficients is checked on every strobe.
module tb_sw_coeff_loader;
    localparam int LOGN = 5;
    localparam int W    = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [1:0] current_n = 2'd0;
    logic       do_expand = 1'b0;
    logic       busy;
    logic       done;

    sw_coeff_loader_if #(.LOGN(LOGN), .W(W)) bus ();

    sw_coeff_loader #(.LOGN(LOGN), .W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .current_n (current_n),
        .do_expand (do_expand),
        .busy      (busy),
        .done      (done),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    logic [2*W-1:0] exp_q[$];
    logic [2*W-1:0] e_dat;
    int exp_addr = 0;
    int exp_total = 0;
    int writes = 0;
    int last_wea_cyc = -100;
    bit prev_wea = 1'b0;
    bit space_chk = 1'b0;
    bit abort = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Number of coefficients a load must produce, straight from the sizing rule.
    function automatic int model_total(input int n, input bit de);
        int k;
        k = (n > 2) ? 2 : n;
        return (1 << (LOGN - 2 + k)) >> de;
    endfunction

    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            prev_wea = 1'b0;
        end else begin
            if (bus.wea_to_expand) begin
                chk("wea_adjacent", 64'(prev_wea), 64'd0);
                chk("s_ready_in_write", 64'(bus.s_ready), 64'd0);
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL extra_strobe: addr %0d data %0h with no coefficient pending",
                             bus.addr_to_expand, bus.data_to_expand);
                end else begin
                    e_dat = exp_q.pop_front();
                    chk("write_data", 64'(bus.data_to_expand), 64'(e_dat));
                    chk("write_addr", 64'(bus.addr_to_expand), 64'(exp_addr));
                end
                if (space_chk && writes > 0) chk("strobe_spacing", 64'(cyc - last_wea_cyc), 64'd4);
                last_wea_cyc = cyc;
                writes++;
                exp_addr++;
            end else if (prev_wea) begin
                chk("s_ready_in_gap", 64'(bus.s_ready), 64'd0);
            end
            if (done) begin
                chk("done_count", 64'(writes), 64'(exp_total));
                chk("done_latency", 64'(cyc - last_wea_cyc), 64'd2);
                chk("busy_in_done", 64'(busy), 64'd1);
            end
            prev_wea = bus.wea_to_expand;
        end
    end

    task automatic send(input logic [W-1:0] w, input int stall);
        int n = 0;
        if (stall > 0) begin
            bus.s_valid = 1'b0;
            repeat (stall) @(negedge clk);
        end
        bus.s_valid = 1'b1;
        bus.s_data  = w;
        while (!bus.s_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!bus.s_ready) begin
            checks++;
            failures++;
            $display("FAIL send_timeout: word %0h not accepted within 40 cycles", w);
            abort = 1'b1;
            bus.s_valid = 1'b0;
            return;
        end
        @(negedge clk);
    endtask

    task automatic do_load(input int n, input bit de, input int hand_total, input int base,
                           input int mode, input bit poke, input bit start_in_done);
        logic [W-1:0] re_w;
        logic [W-1:0] im_w;
        int t = 0;
        exp_q.delete();
        writes    = 0;
        exp_addr  = 0;
        exp_total = model_total(n, de);
        abort     = 1'b0;
        space_chk = (mode == 0);
        for (int i = 0; i < hand_total; i++) begin
            re_w = W'(base + 2 * i);
            im_w = W'(base + 2 * i + 1);
            exp_q.push_back({re_w, im_w});
        end
        current_n = 2'(n);
        do_expand = de;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_start", 64'(busy), 64'd1);
        for (int i = 0; i < hand_total && !abort; i++) begin
            re_w = W'(base + 2 * i);
            im_w = W'(base + 2 * i + 1);
            send(re_w, (mode != 0) ? int'($urandom_range(0, 2)) : 0);
            if (abort) break;
            send(im_w, (mode != 0) ? int'($urandom_range(0, 3)) : 0);
            if (poke && i == 1) begin
                start     = 1'b1;
                current_n = (n == 2) ? 2'd0 : 2'd2;
                do_expand = ~de;
                @(negedge clk);
                start = 1'b0;
            end
        end
        bus.s_valid = 1'b0;
        if (abort) return;
        while (!done && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL done_timeout: no done within 20 cycles after last word");
            return;
        end
        if (start_in_done) start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_done", 64'(busy), 64'd0);
        chk("done_one_cycle", 64'(done), 64'd0);
        chk("writes_vs_hand", 64'(writes), 64'(hand_total));
        chk("addr_hold_idle", 64'(bus.addr_to_expand), 64'(hand_total - 1));
        re_w = W'(base + 2 * (hand_total - 1));
        im_w = W'(base + 2 * (hand_total - 1) + 1);
        chk("data_hold_idle", 64'(bus.data_to_expand), 64'({re_w, im_w}));
        if (start_in_done) begin
            repeat (3) @(negedge clk);
            chk("start_in_done_ignored", 64'(busy), 64'd0);
        end
    endtask

    initial begin
        bus.s_data  = '0;
        bus.s_valid = 1'b0;
        #3;
        chk("reset_s_ready", 64'(bus.s_ready), 64'd0);
        chk("reset_wea", 64'(bus.wea_to_expand), 64'd0);
        chk("reset_addr", 64'(bus.addr_to_expand), 64'd0);
        chk("reset_data", 64'(bus.data_to_expand), 64'd0);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_done", 64'(done), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("idle_s_ready", 64'(bus.s_ready), 64'd0);

        do_load(0, 1'b0, 8, 0, 0, 1'b0, 1'b0);
        do_load(2, 1'b1, 16, 'h100, 0, 1'b0, 1'b0);
        do_load(3, 1'b1, 16, 'h100, 0, 1'b0, 1'b0);
        do_load(1, 1'b0, 16, 'h200, 1, 1'b0, 1'b0);

        // Abort a load with an asynchronous reset in the gap after its third write.
        exp_q.delete();
        writes    = 0;
        exp_addr  = 0;
        exp_total = model_total(0, 1'b0);
        abort     = 1'b0;
        space_chk = 1'b1;
        for (int i = 0; i < 8; i++) exp_q.push_back({W'(2 * i), W'(2 * i + 1)});
        current_n = 2'd0;
        do_expand = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 3 && !abort; i++) begin
            send(W'(2 * i), 0);
            send(W'(2 * i + 1), 0);
        end
        bus.s_valid = 1'b0;
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_s_ready", 64'(bus.s_ready), 64'd0);
        chk("midrst_wea", 64'(bus.wea_to_expand), 64'd0);
        chk("midrst_addr", 64'(bus.addr_to_expand), 64'd0);
        chk("midrst_data", 64'(bus.data_to_expand), 64'd0);
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_done", 64'(done), 64'd0);
        chk("writes_before_rst", 64'(writes), 64'd3);
        exp_q.delete();
        writes = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        chk("no_strobe_after_rst", 64'(writes), 64'd0);
        chk("idle_after_rst", 64'(busy), 64'd0);

        do_load(2, 1'b0, 32, 'h300, 0, 1'b0, 1'b0);
        do_load(1, 1'b1, 8, 'h400, 0, 1'b1, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end
endmodule
